// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared BCD constants and digit helpers for the up/down counter
// Revision    : 1.0  initial release
// ============================================================================
package bcd_pkg;

  // Largest legal value of one BCD digit
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // Replace any non-BCD nibble (10..15) with 9
  function automatic logic [3:0] clamp_bcd_digit(input logic [3:0] d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_addsub.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_addsub
// Description : One BCD digit adder/subtractor. Subtraction adds the nines
//               complement of b; the chain's carry-in of 1 completes the tens
//               complement, and a final carry-out of 1 means "no borrow".
// Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_addsub
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] y,
  output logic       cout
);

  logic [3:0] b_eff;
  logic [4:0] raw;

  // Binary digit sum followed by decimal adjust (raw is at most 19)
  always_comb begin
    b_eff = sub ? (DIGIT_MAX - b) : b;
    raw   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
    if (raw > 5'd9) begin
      y    = raw[3:0] + 4'd6;
      cout = 1'b1;
    end else begin
      y    = raw[3:0];
      cout = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/btn_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : btn_edge_sync
// Description : Button synchroniser plus registered rising-edge detector.
//               Detection is armed only after the synchronised level has been
//               seen low with the chain fully refilled since reset, so a
//               button held through reset yields no event on reset release.
// Revision    : 1.0  initial release
// ============================================================================
module btn_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic ev_o
);

  // Fewer than two stages is not a safe synchroniser
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] fill_q;
  logic              prev_q;
  logic              armed_q;
  logic              ev_q;
  logic              lvl;

  assign lvl  = sync_q[STAGES-1];
  assign ev_o = ev_q;

  // Synchronise, track fill after reset, arm on first valid low, flag rises
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      ev_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], btn_i};
      fill_q  <= {fill_q[STAGES-2:0], 1'b1};
      prev_q  <= lvl;
      armed_q <= armed_q | (fill_q[STAGES-1] & ~lvl);
      ev_q    <= armed_q & lvl & ~prev_q;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_updown_counter
// Description : Signed (sign-magnitude) BCD up/down counter with selectable
//               step, wrap/saturate limits, synchronous clear and load.
// Revision    : 1.0  initial release
// ============================================================================
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_inc,
  input  logic                btn_dec,
  input  logic [3:0]          step,
  input  logic                sat_mode,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_bcd,
  input  logic                load_sign,
  output logic [4*DIGITS-1:0] bcd,
  output logic                sign,
  output logic                zero,
  output logic                ovf
);

  localparam int            W       = 4 * DIGITS;
  localparam logic [W-1:0]  MAX_BCD = {DIGITS{DIGIT_MAX}};

  logic [W-1:0] bcd_q, bcd_d;
  logic         sign_q, sign_d;
  logic         zero_q;
  logic         ovf_q, ovf_d;

  logic         inc_ev, dec_ev;
  logic [3:0]   step_eff;
  logic [W-1:0] s_vec;
  logic [W-1:0] load_clean;
  logic [W-1:0] add_y, sub_y, rsub_y;
  logic [DIGITS:0] add_c, sub_c, rsub_c;
  logic         ev_inc, ev_dec, same_dir;

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_inc_edge (
    .clk  (clk),
    .reset(reset),
    .btn_i(btn_inc),
    .ev_o (inc_ev)
  );

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dec_edge (
    .clk  (clk),
    .reset(reset),
    .btn_i(btn_dec),
    .ev_o (dec_ev)
  );

  assign step_eff = clamp_bcd_digit(step);

  // Step widened to the full digit vector (upper digits zero)
  always_comb begin
    s_vec      = '0;
    s_vec[3:0] = step_eff;
  end

  // Three ripple chains: bcd+s, bcd-s and s-bcd; carry-out of the add chain
  // flags crossing the all-nines limit, carry-out of bcd-s means bcd >= s.
  assign add_c[0]  = 1'b0;
  assign sub_c[0]  = 1'b1;
  assign rsub_c[0] = 1'b1;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign load_clean[4*i +: 4] = clamp_bcd_digit(load_bcd[4*i +: 4]);

      bcd_digit_addsub u_add (
        .a   (bcd_q[4*i +: 4]),
        .b   (s_vec[4*i +: 4]),
        .cin (add_c[i]),
        .sub (1'b0),
        .y   (add_y[4*i +: 4]),
        .cout(add_c[i+1])
      );

      bcd_digit_addsub u_sub (
        .a   (bcd_q[4*i +: 4]),
        .b   (s_vec[4*i +: 4]),
        .cin (sub_c[i]),
        .sub (1'b1),
        .y   (sub_y[4*i +: 4]),
        .cout(sub_c[i+1])
      );

      bcd_digit_addsub u_rsub (
        .a   (s_vec[4*i +: 4]),
        .b   (bcd_q[4*i +: 4]),
        .cin (rsub_c[i]),
        .sub (1'b1),
        .y   (rsub_y[4*i +: 4]),
        .cout(rsub_c[i+1])
      );
    end
  endgenerate

  // Simultaneous inc and dec cancel; same_dir means the magnitude grows
  assign ev_inc   = inc_ev & ~dec_ev;
  assign ev_dec   = dec_ev & ~inc_ev;
  assign same_dir = ev_inc ? ~sign_q : sign_q;

  // Next-state selection: clear > load > single event with non-zero step
  always_comb begin
    bcd_d  = bcd_q;
    sign_d = sign_q;
    ovf_d  = 1'b0;
    if (clear) begin
      bcd_d  = '0;
      sign_d = 1'b0;
    end else if (load) begin
      bcd_d  = load_clean;
      sign_d = load_sign & (|load_clean);
    end else if ((ev_inc | ev_dec) && (step_eff != 4'd0)) begin
      if (same_dir) begin
        if (add_c[DIGITS]) begin
          ovf_d = 1'b1;
          bcd_d = sat_mode ? MAX_BCD : add_y;
        end else begin
          bcd_d = add_y;
        end
        // a wrap can land exactly on zero; never leave a negative zero
        sign_d = sign_q & (|bcd_d);
      end else if (sub_c[DIGITS]) begin
        bcd_d  = sub_y;
        sign_d = sign_q & (|sub_y);
      end else begin
        bcd_d  = rsub_y;
        sign_d = ~sign_q;
      end
    end
  end

  // Output registers; zero is registered alongside the magnitude it reflects
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_q  <= '0;
      sign_q <= 1'b0;
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      sign_q <= sign_d;
      zero_q <= ~|bcd_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bcd  = bcd_q;
  assign sign = sign_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_updown_counter
// Description : Scoreboard bench for bcd_updown_counter (DIGITS=4 and 2)
// Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, btn_inc, btn_dec, sat_mode, clear, load, load_sign;
  logic [3:0]  step;
  logic [15:0] load_bcd, bcd;
  logic        sign, zero, ovf;

  logic        b2_inc, b2_dec, b2_clear, b2_load, b2_load_sign;
  logic [7:0]  b2_load_bcd, bcd2;
  logic        sign2, zero2, ovf2;

  bcd_updown_counter #(.DIGITS(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .step(step), .sat_mode(sat_mode), .clear(clear), .load(load),
    .load_bcd(load_bcd), .load_sign(load_sign),
    .bcd(bcd), .sign(sign), .zero(zero), .ovf(ovf)
  );

  bcd_updown_counter #(.DIGITS(2), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .reset(reset), .btn_inc(b2_inc), .btn_dec(b2_dec),
    .step(step), .sat_mode(sat_mode), .clear(b2_clear), .load(b2_load),
    .load_bcd(b2_load_bcd), .load_sign(b2_load_sign),
    .bcd(bcd2), .sign(sign2), .zero(zero2), .ovf(ovf2)
  );

  int total = 0;
  int bad   = 0;
  int mv    = 0;
  int mv2   = 0;
  logic [18:0] exp_q[$];
  logic [18:0] obs, obs_early, obs_next, e;
  bit          ov;

  // {bcd, sign, zero, ovf} of the 4-digit instance
  function automatic logic [18:0] cur();
    return {bcd, sign, zero, ovf};
  endfunction

  function automatic logic [15:0] to_bcd(input int m);
    logic [15:0] r;
    int t;
    t = m;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [18:0] pack_exp(input int v, input bit o);
    int m;
    m = (v < 0) ? -v : v;
    return {to_bcd(m), (v < 0), (v == 0), o};
  endfunction

  function automatic int load_val(input logic [15:0] x, input bit sg);
    int m;
    logic [3:0] d;
    m = 0;
    for (int i = 3; i >= 0; i--) begin
      d = x[4*i +: 4];
      if (d > 4'd9) d = 4'd9;
      m = m * 10 + int'(d);
    end
    return (sg && m != 0) ? -m : m;
  endfunction

  // Reference: signed value V moves by +/-s; limits wrap or clamp
  task automatic model_event(inout int v, input bit inc, input bit dec,
                             input int maxv, output bit o);
    int s, r;
    s = (int'(step) > 9) ? 9 : int'(step);
    o = 1'b0;
    if (inc == dec || s == 0) return;
    r = inc ? v + s : v - s;
    if (r > maxv) begin
      o = 1'b1;
      r = sat_mode ? maxv : r - (maxv + 1);
    end else if (r < -maxv) begin
      o = 1'b1;
      r = sat_mode ? -maxv : r + (maxv + 1);
    end
    v = r;
  endtask

  // Button press: sample one cycle before, at, and one cycle after the update
  task automatic press(input bit inc, input bit dec);
    @(negedge clk); btn_inc = inc; btn_dec = dec;
    repeat (3) @(posedge clk);
    #1 obs_early = cur();
    @(posedge clk);
    #1 obs = cur();
    @(posedge clk);
    #1 obs_next = cur();
    @(negedge clk); btn_inc = 1'b0; btn_dec = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic do_load(input logic [15:0] val, input bit sg);
    @(negedge clk); load = 1'b1; load_bcd = val; load_sign = sg;
    @(posedge clk);
    #1 obs = cur();
    @(negedge clk); load = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(posedge clk);
    #1 obs = cur();
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; btn_inc = 1'b1;
    repeat (3) @(posedge clk);
    #1 obs = cur();
    exp_q.push_back(pack_exp(0, 1'b0));
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL reset_state got=%h exp=%h", obs, e); end
    @(negedge clk); reset = 1'b1;
    repeat (10) @(posedge clk);
    #1 obs = cur();
    exp_q.push_back(pack_exp(0, 1'b0));
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL held_through_reset got=%h exp=%h", obs, e); end
    @(negedge clk); btn_inc = 1'b0;
    repeat (4) @(posedge clk);
    step = 4'd1;
    model_event(mv, 1'b1, 1'b0, 9999, ov);
    exp_q.push_back(pack_exp(mv, ov));
    press(1'b1, 1'b0);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL first_press got=%h exp=%h", obs, e); end
    mv = 0;
    exp_q.push_back(pack_exp(mv, 1'b0));
    do_clear();
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL clear got=%h exp=%h", obs, e); end
  endtask

  task automatic test_step_seq();
    logic [3:0] steps [6];
    bit         incs  [6];
    steps = '{4'd5, 4'd5, 4'd5, 4'd7, 4'd7, 4'd7};
    incs  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    sat_mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step = steps[i];
      exp_q.push_back(pack_exp(mv, 1'b0));
      model_event(mv, incs[i], !incs[i], 9999, ov);
      exp_q.push_back(pack_exp(mv, ov));
      press(incs[i], !incs[i]);
      e = exp_q.pop_front(); total++;
      if (obs_early !== e) begin bad++; $display("FAIL latency_%0d got=%h exp=%h", i, obs_early, e); end
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL step_seq_%0d got=%h exp=%h", i, obs, e); end
    end
  endtask

  task automatic test_no_neg_zero();
    mv = load_val(16'h0001, 1'b1);
    exp_q.push_back(pack_exp(mv, 1'b0));
    do_load(16'h0001, 1'b1);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL load_neg1 got=%h exp=%h", obs, e); end
    step = 4'd1;
    model_event(mv, 1'b1, 1'b0, 9999, ov);
    exp_q.push_back(pack_exp(mv, ov));
    press(1'b1, 1'b0);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL no_neg_zero got=%h exp=%h", obs, e); end
  endtask

  task automatic test_limits();
    bit sats [3];
    bit sgs  [3];
    sats = '{1'b1, 1'b0, 1'b1};
    sgs  = '{1'b0, 1'b0, 1'b1};
    step = 4'd3;
    for (int i = 0; i < 3; i++) begin
      sat_mode = sats[i];
      do_load(16'h9998, sgs[i]);
      mv = load_val(16'h9998, sgs[i]);
      model_event(mv, !sgs[i], sgs[i], 9999, ov);
      exp_q.push_back(pack_exp(mv, ov));
      exp_q.push_back(pack_exp(mv, 1'b0));
      press(!sgs[i], sgs[i]);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL limit_%0d got=%h exp=%h", i, obs, e); end
      e = exp_q.pop_front(); total++;
      if (obs_next !== e) begin bad++; $display("FAIL ovf_one_cycle_%0d got=%h exp=%h", i, obs_next, e); end
    end
    sat_mode = 1'b0;
  endtask

  task automatic test_step_clamp();
    mv = 0;
    exp_q.push_back(pack_exp(mv, 1'b0));
    do_clear();
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL clear2 got=%h exp=%h", obs, e); end
    step = 4'd12;
    model_event(mv, 1'b1, 1'b0, 9999, ov);
    exp_q.push_back(pack_exp(mv, ov));
    press(1'b1, 1'b0);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL step_clamp got=%h exp=%h", obs, e); end
    for (int sg = 0; sg < 2; sg++) begin
      mv = load_val(16'hA3F2, sg[0]);
      exp_q.push_back(pack_exp(mv, 1'b0));
      do_load(16'hA3F2, sg[0]);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL load_clamp_%0d got=%h exp=%h", sg, obs, e); end
    end
  endtask

  task automatic test_simul_and_zero_step();
    step = 4'd2;
    model_event(mv, 1'b1, 1'b1, 9999, ov);
    exp_q.push_back(pack_exp(mv, ov));
    press(1'b1, 1'b1);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL simul_inc_dec got=%h exp=%h", obs, e); end
    step = 4'd0;
    model_event(mv, 1'b0, 1'b1, 9999, ov);
    exp_q.push_back(pack_exp(mv, ov));
    press(1'b0, 1'b1);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL zero_step got=%h exp=%h", obs, e); end
  endtask

  task automatic test_load_during_event();
    step = 4'd1;
    mv = load_val(16'h0042, 1'b0);
    exp_q.push_back(pack_exp(mv, 1'b0));
    exp_q.push_back(pack_exp(mv, 1'b0));
    @(negedge clk); btn_inc = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); load = 1'b1; load_bcd = 16'h0042; load_sign = 1'b0;
    @(posedge clk);
    #1 obs = cur();
    @(negedge clk); load = 1'b0; btn_inc = 1'b0;
    repeat (6) @(posedge clk);
    #1 obs_next = cur();
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL load_beats_event got=%h exp=%h", obs, e); end
    e = exp_q.pop_front(); total++;
    if (obs_next !== e) begin bad++; $display("FAIL event_not_replayed got=%h exp=%h", obs_next, e); end
  endtask

  task automatic test_digits2();
    sat_mode = 1'b0;
    step = 4'd4;
    @(negedge clk); b2_load = 1'b1; b2_load_bcd = 8'h98; b2_load_sign = 1'b0;
    @(posedge clk);
    @(negedge clk); b2_load = 1'b0;
    mv2 = 98;
    model_event(mv2, 1'b1, 1'b0, 99, ov);
    exp_q.push_back(pack_exp(mv2, ov));
    @(negedge clk); b2_inc = 1'b1;
    repeat (4) @(posedge clk);
    #1 obs = {8'h00, bcd2, sign2, zero2, ovf2};
    @(negedge clk); b2_inc = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL digits2_wrap got=%h exp=%h", obs, e); end
  endtask

  initial begin
    reset = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; sat_mode = 1'b0;
    clear = 1'b0; load = 1'b0; load_sign = 1'b0; step = 4'd0; load_bcd = '0;
    b2_inc = 1'b0; b2_dec = 1'b0; b2_clear = 1'b0; b2_load = 1'b0;
    b2_load_sign = 1'b0; b2_load_bcd = '0;
    test_reset();
    test_step_seq();
    test_no_neg_zero();
    test_limits();
    test_step_clamp();
    test_simul_and_zero_step();
    test_load_during_event();
    test_digits2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
